// File: rtl/eusci_uart_pkg.sv
// Shared definitions for the eUSCI UART receive path.
// Covers FSM encodings, the receive-FIFO word layout and the legal data-width range.
package eusci_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP2  = 3'd4,
    ST_STOP1  = 3'd5
  } rx_state_t;

  // FIFO word = {BRK, FE, PE, data}; flag positions are offsets above the data field.
  localparam int DATA_LSB = 0;
  localparam int PE_BIT   = 0;
  localparam int FE_BIT   = 1;
  localparam int BRK_BIT  = 2;
  localparam int FLAG_W   = 3;

  localparam logic [3:0] DBITS_MIN = 4'd5;

  function automatic logic [3:0] clamp_dbits(input logic [3:0] v, input logic [3:0] vmax);
    logic [3:0] r;
    r = v;
    if (v < DBITS_MIN) r = DBITS_MIN;
    if (v > vmax)      r = vmax;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_engine_rx_fifo.sv
// Synchronous show-ahead FIFO; the head word is visible without a pop.
// A push into a full FIFO succeeds only when a pop happens on the same edge.
module rx_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           srst,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_wdata,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_rdata,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_engine.sv
// eUSCI UART receiver: oversampled majority-vote bit recovery, false-start rejection,
// per-frame config shadowing and a show-ahead FIFO carrying per-character error flags.
module uart_rx_engine
  import eusci_uart_pkg::*;
#(
  parameter int DATA_MAX   = 9,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              MCLK,
  input  logic                              reset,
  input  logic                              sampleTick,
  input  logic                              Rx,
  input  logic                              cfgEnable,
  input  logic [3:0]                        cfgDataBits,
  input  logic                              cfgPEN,
  input  logic                              cfgPAR,
  input  logic                              cfgMSB,
  input  logic                              cfgSPB,
  input  logic                              cfgRXEIE,
  input  logic                              rdEn,
  output logic [DATA_MAX-1:0]               RxData,
  output logic                              RxPE,
  output logic                              RxFE,
  output logic                              RxBRK,
  output logic                              RxValid,
  output logic                              RxOE,
  output logic                              RxBusy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifoCount
);

  localparam int TW = $clog2(OVS);
  localparam int WW = DATA_MAX + FLAG_W;
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_S0   = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVS/2);
  localparam logic [TW-1:0] T_RES  = TW'(OVS/2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);

  rx_state_t r_state, w_state_next;

  logic [TW-1:0]       r_tick_cnt;
  logic [3:0]          r_bit_cnt;
  logic                r_s0, r_s1, r_last_sample;
  logic [DATA_MAX-1:0] r_data;
  logic                r_par, r_pe, r_fe, r_all_zero;
  logic [3:0]          r_dbits;
  logic                r_pen, r_par_even, r_msb, r_spb, r_rxeie;
  logic                r_push, r_oe;
  logic [WW-1:0]       r_push_word;

  logic                w_clr, w_maj, w_active, w_start, w_resolve, w_bound, w_last_data;
  logic [3:0]          w_idx;
  logic                w_fe_final, w_brk_final, w_complete, w_push_ok;
  logic [WW-1:0]       w_word;
  logic                w_pop, w_full, w_empty;
  logic [WW-1:0]       w_head;

  assign w_clr       = reset | ~cfgEnable;
  assign w_maj       = (r_s0 & r_s1) | (r_s0 & Rx) | (r_s1 & Rx);
  assign w_active    = (r_state != ST_IDLE);
  assign w_start     = sampleTick & ~w_active & r_last_sample & ~Rx;
  assign w_resolve   = sampleTick & w_active & (r_tick_cnt == T_RES);
  assign w_bound     = sampleTick & w_active & (r_tick_cnt == T_LAST);
  assign w_last_data = (r_bit_cnt == r_dbits - 4'd1);
  assign w_idx       = r_msb ? (r_dbits - 4'd1 - r_bit_cnt) : r_bit_cnt;

  // FSM: state register
  always_ff @(posedge MCLK) begin
    if (w_clr) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_start) w_state_next = ST_START;
      ST_START: begin
        if (w_resolve && w_maj) w_state_next = ST_IDLE;
        else if (w_bound)       w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_bound && w_last_data)
          w_state_next = r_pen ? ST_PARITY : (r_spb ? ST_STOP2 : ST_STOP1);
      end
      ST_PARITY: if (w_bound) w_state_next = r_spb ? ST_STOP2 : ST_STOP1;
      ST_STOP2:  if (w_bound) w_state_next = ST_STOP1;
      ST_STOP1:  if (w_resolve) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs; a frame completes mid stop bit so the next start edge is never missed
  always_comb begin
    RxBusy      = w_active;
    w_fe_final  = r_fe | ~w_maj;
    w_brk_final = r_all_zero & ~w_maj;
    w_complete  = w_resolve & (r_state == ST_STOP1);
    w_push_ok   = w_complete & (r_rxeie | ~(r_pe | w_fe_final | w_brk_final));
    w_word      = '0;
    w_word[DATA_MAX-1:DATA_LSB]  = r_data;
    w_word[DATA_MAX + PE_BIT]    = r_pe;
    w_word[DATA_MAX + FE_BIT]    = w_fe_final;
    w_word[DATA_MAX + BRK_BIT]   = w_brk_final;
  end

  always_ff @(posedge MCLK) begin
    if (w_clr) begin
      r_tick_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_s0          <= 1'b1;
      r_s1          <= 1'b1;
      r_last_sample <= 1'b1;
      r_data        <= '0;
      r_par         <= 1'b0;
      r_pe          <= 1'b0;
      r_fe          <= 1'b0;
      r_all_zero    <= 1'b0;
      r_dbits       <= DBITS_MIN;
      r_pen         <= 1'b0;
      r_par_even    <= 1'b0;
      r_msb         <= 1'b0;
      r_spb         <= 1'b0;
      r_rxeie       <= 1'b0;
      r_push        <= 1'b0;
      r_push_word   <= '0;
    end else begin
      r_push      <= w_push_ok;
      r_push_word <= w_word;
      if (sampleTick) r_last_sample <= Rx;
      if (w_start) begin
        r_tick_cnt <= T_ONE;
        r_bit_cnt  <= '0;
        r_data     <= '0;
        r_par      <= 1'b0;
        r_pe       <= 1'b0;
        r_fe       <= 1'b0;
        r_all_zero <= 1'b1;
        r_dbits    <= clamp_dbits(cfgDataBits, 4'(DATA_MAX));
        r_pen      <= cfgPEN;
        r_par_even <= cfgPAR;
        r_msb      <= cfgMSB;
        r_spb      <= cfgSPB;
        r_rxeie    <= cfgRXEIE;
      end else if (sampleTick && w_active) begin
        r_tick_cnt <= (r_tick_cnt == T_LAST) ? '0 : r_tick_cnt + T_ONE;
        if (r_tick_cnt == T_S0) r_s0 <= Rx;
        if (r_tick_cnt == T_S1) r_s1 <= Rx;
        if (w_resolve) begin
          r_all_zero <= r_all_zero & ~w_maj;
          unique case (r_state)
            ST_DATA: begin
              for (int i = 0; i < DATA_MAX; i++)
                if (w_idx == 4'(i)) r_data[i] <= w_maj;
              r_par <= r_par ^ w_maj;
            end
            ST_PARITY: r_pe <= r_par_even ? (r_par ^ w_maj) : ~(r_par ^ w_maj);
            ST_STOP2:  r_fe <= ~w_maj;
            default:   ;
          endcase
        end
        if (w_bound && r_state == ST_DATA) r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end
  end

  assign w_pop = rdEn & ~w_empty;

  // Overrun only when the push really finds no room, i.e. no pop on the same edge
  always_ff @(posedge MCLK) begin
    if (w_clr)                          r_oe <= 1'b0;
    else if (w_pop)                     r_oe <= 1'b0;
    else if (r_push && w_full)          r_oe <= 1'b1;
  end

  rx_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (MCLK),
    .srst    (w_clr),
    .i_push  (r_push),
    .i_wdata (r_push_word),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifoCount)
  );

  always_comb begin
    RxData  = w_empty ? '0 : w_head[DATA_MAX-1:DATA_LSB];
    RxPE    = ~w_empty & w_head[DATA_MAX + PE_BIT];
    RxFE    = ~w_empty & w_head[DATA_MAX + FE_BIT];
    RxBRK   = ~w_empty & w_head[DATA_MAX + BRK_BIT];
    RxValid = ~w_empty;
    RxOE    = r_oe;
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: one sampleTick every second MCLK, OVS = 16.
// Inputs change and outputs are sampled on the falling edge.
module tb_uart_rx_engine;

  logic       MCLK = 1'b0;
  logic       reset, sampleTick, Rx, cfgEnable;
  logic [3:0] cfgDataBits;
  logic       cfgPEN, cfgPAR, cfgMSB, cfgSPB, cfgRXEIE, rdEn;
  logic [8:0] RxData;
  logic       RxPE, RxFE, RxBRK, RxValid, RxOE, RxBusy;
  logic [2:0] fifoCount;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_engine #(.DATA_MAX(9), .OVS(16), .FIFO_DEPTH(4)) dut (
    .MCLK(MCLK), .reset(reset), .sampleTick(sampleTick), .Rx(Rx),
    .cfgEnable(cfgEnable), .cfgDataBits(cfgDataBits), .cfgPEN(cfgPEN),
    .cfgPAR(cfgPAR), .cfgMSB(cfgMSB), .cfgSPB(cfgSPB), .cfgRXEIE(cfgRXEIE),
    .rdEn(rdEn), .RxData(RxData), .RxPE(RxPE), .RxFE(RxFE), .RxBRK(RxBRK),
    .RxValid(RxValid), .RxOE(RxOE), .RxBusy(RxBusy), .fifoCount(fifoCount)
  );

  always #5 MCLK = ~MCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      sampleTick = 1'b1;
      @(negedge MCLK);
      sampleTick = 1'b0;
      @(negedge MCLK);
    end
  endtask

  task automatic set_cfg(input logic [3:0] dbits, input bit pen, input bit par,
                         input bit msb, input bit spb, input bit rxeie);
    cfgDataBits = dbits; cfgPEN = pen; cfgPAR = par;
    cfgMSB = msb; cfgSPB = spb; cfgRXEIE = rxeie;
  endtask

  task automatic send_frame(input logic [8:0] d, input int nbits, input bit msb,
                            input bit pen, input bit pbit, input int nstop);
    Rx = 1'b0; ticks(16);
    for (int i = 0; i < nbits; i++) begin
      Rx = msb ? d[nbits-1-i] : d[i];
      ticks(16);
    end
    if (pen) begin Rx = pbit; ticks(16); end
    Rx = 1'b1;
    ticks(16 * nstop + 2);
  endtask

  task automatic pop;
    rdEn = 1'b1;
    @(negedge MCLK);
    rdEn = 1'b0;
  endtask

  initial begin
    logic [8:0] d;
    reset = 1'b1; sampleTick = 1'b0; Rx = 1'b1; cfgEnable = 1'b1; rdEn = 1'b0;
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge MCLK);
    check_eq("rst_valid", RxValid, 0);
    check_eq("rst_busy",  RxBusy,  0);
    check_eq("rst_count", fifoCount, 0);
    check_eq("rst_oe",    RxOE, 0);
    check_eq("rst_data",  RxData, 0);
    reset = 1'b0;
    ticks(4);

    // 1: 8N1 LSB-first 0x5A with exact timing of busy and valid
    d = 9'h05A;
    Rx = 1'b0; sampleTick = 1'b1; @(negedge MCLK);
    check_eq("t1_busy_start", RxBusy, 1);
    sampleTick = 1'b0; @(negedge MCLK);
    ticks(15);
    for (int i = 0; i < 8; i++) begin Rx = d[i]; ticks(16); end
    Rx = 1'b1; ticks(9);
    check_eq("t1_busy_prestop", RxBusy, 1);
    check_eq("t1_valid_prestop", RxValid, 0);
    sampleTick = 1'b1; @(negedge MCLK);
    check_eq("t1_busy_done", RxBusy, 0);
    check_eq("t1_valid_edge", RxValid, 0);
    sampleTick = 1'b0; @(negedge MCLK);
    check_eq("t1_valid", RxValid, 1);
    check_eq("t1_data", RxData, 9'h05A);
    check_eq("t1_flags", {RxBRK, RxFE, RxPE}, 0);
    check_eq("t1_count", fifoCount, 1);
    ticks(8);
    pop();
    check_eq("t1_empty", RxValid, 0);

    // 2: 7E2 MSB-first 0x41 with a wrong parity bit (correct even parity is 0)
    set_cfg(4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1, 2);
    check_eq("t2_drop_valid", RxValid, 0);
    cfgRXEIE = 1'b1;
    send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1, 2);
    check_eq("t2_valid", RxValid, 1);
    check_eq("t2_data", RxData, 9'h041);
    check_eq("t2_pe", RxPE, 1);
    check_eq("t2_fe", RxFE, 0);
    pop();

    // 3: 4-tick glitch is a false start, then 0x33 is received
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    Rx = 1'b0; ticks(4);
    Rx = 1'b1; ticks(12);
    check_eq("t3_busy", RxBusy, 0);
    check_eq("t3_count", fifoCount, 0);
    ticks(4);
    send_frame(9'h033, 8, 1'b0, 1'b0, 1'b0, 1);
    check_eq("t3_data", RxData, 9'h033);
    check_eq("t3_count2", fifoCount, 1);
    pop();

    // 4: five frames into a depth-4 FIFO: overrun, fifth character lost
    for (int k = 1; k <= 5; k++) begin
      d = 9'(k);
      send_frame(d, 8, 1'b0, 1'b0, 1'b0, 1);
    end
    check_eq("t4_count", fifoCount, 4);
    check_eq("t4_oe", RxOE, 1);
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("t4_pop%0d", k), RxData, k);
      pop();
      if (k == 1) check_eq("t4_oe_clr", RxOE, 0);
    end
    check_eq("t4_empty", RxValid, 0);

    // 5: line held low for 12 bit times gives exactly one break entry
    cfgRXEIE = 1'b1;
    Rx = 1'b0; ticks(192);
    check_eq("t5_count", fifoCount, 1);
    check_eq("t5_busy", RxBusy, 0);
    Rx = 1'b1; ticks(20);
    check_eq("t5_count2", fifoCount, 1);
    check_eq("t5_data", RxData, 0);
    check_eq("t5_flags", {RxBRK, RxFE, RxPE}, 3'b110);

    // 6: reset in bit 3 clears everything on the next MCLK; 0xA5 follows intact
    d = 9'h0FF;
    Rx = 1'b0; ticks(16);
    for (int i = 0; i < 3; i++) begin Rx = d[i]; ticks(16); end
    Rx = d[3]; ticks(8);
    check_eq("t6_busy_pre", RxBusy, 1);
    reset = 1'b1; @(negedge MCLK);
    check_eq("t6_busy", RxBusy, 0);
    check_eq("t6_valid", RxValid, 0);
    check_eq("t6_count", fifoCount, 0);
    check_eq("t6_head", {RxBRK, RxFE, RxPE, RxData}, 0);
    reset = 1'b0;
    Rx = 1'b1; ticks(20);
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1);
    check_eq("t6_data", RxData, 9'h0A5);
    check_eq("t6_flags", {RxBRK, RxFE, RxPE}, 0);
    check_eq("t6_count2", fifoCount, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
Parametrised eUSCI UART receive engine running on MCLK with an oversampling tick enable. It replaces the separate bit-clock receiver with:
- configurable data width;
- majority-vote mid-bit sampling and false-start rejection;
- a show-ahead receive FIFO that stores per-character error flags.

It sits between the Rx pin synchroniser and the eUSCI register/IFG logic.

Parameters:
DATA_MAX, 9, maximum data bits per character (cfgDataBits range 5..DATA_MAX)
OVS, 16, sampleTick pulses per bit time (even, >=8)
FIFO_DEPTH, 4, receive FIFO entries (power of 2, >=2)

Ports:
MCLK  in  1  system clock
reset  in  1  synchronous, active-high reset
sampleTick  in  1  one-MCLK pulse at OVS x baud rate
Rx  in  1  receive line, already synchronised to MCLK
cfgEnable  in  1  0 = receiver held idle, FIFO flushed
cfgDataBits  in  4  data bits per character, 5..DATA_MAX
cfgPEN, cfgPAR, cfgMSB, cfgSPB, cfgRXEIE  in  1 each  parity enable; 1 = even parity; MSB first; 2 stop bits; accept erroneous characters
rdEn  in  1  pop FIFO head (ignored when empty)
RxData  out  DATA_MAX  head character, right-justified
RxPE, RxFE, RxBRK  out  1 each  head-entry parity, framing and break flags
RxValid  out  1  FIFO not empty (drives RXIFG)
RxOE  out  1  sticky overrun
RxBusy  out  1  frame in progress
fifoCount  out  $clog2(FIFO_DEPTH+1)  occupancy

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, FIFO empty, lastSample = 1. cfgEnable=0 gives the same state, except that it is applied each cycle.
- Sampling:
  - All FSM activity advances only on MCLK edges where sampleTick=1.
  - tickCnt counts 0..OVS-1 within each bit.
  - Bit value = majority of Rx at tickCnt OVS/2-1, OVS/2 and OVS/2+1, resolved at OVS/2+1.
- States: IDLE, START, DATA, PARITY, STOP2, STOP1.
- IDLE:
  - A start is a tick where lastSample=1 and Rx=0. On a start: go to START, tickCnt=1, RxBusy=1.
  - Config inputs are latched into shadow registers for the frame. Config changes mid-frame have no effect until the next START.
  - A line held low never retriggers; a 1 must be seen first.
- START: majority=1 means false start: back to IDLE, RxBusy=0, no flags, no push. Otherwise go to DATA at the bit boundary.
- DATA:
  - bitCnt runs 0..cfgDataBits-1; each bit is shifted into a DATA_MAX register.
  - Then go to PARITY if cfgPEN, else STOP2 if cfgSPB, else STOP1.
- PARITY: p = XOR of the data bits and the parity bit. PE = p when even parity is selected, PE = ~p when odd.
- STOP2: FE = ~bit. Then go to STOP1.
- STOP1:
  - FE |= ~bit.
  - BRK = 1 when every sampled bit of the frame, including parity and stop bits, is 0.
  - The frame completes at the resolve tick (mid stop bit, not end of bit), so back-to-back frames are supported. FSM returns to IDLE and RxBusy=0 on the same edge.
- Data ordering: when cfgMSB=1, the first received bit lands in bit cfgDataBits-1. Upper bits above cfgDataBits are 0.
- Push:
  - Pushed word = {BRK, FE, PE, data}.
  - Pushed at the completion edge when cfgRXEIE=1 or PE|FE|BRK=0. Otherwise the character is discarded silently.
  - RxValid rises one MCLK after the completion edge.
- FIFO full:
  - On a push attempt when full: the word is dropped, RxOE is set, and the existing contents are unchanged.
  - Simultaneous pop and push when full: pop first, the push succeeds, RxOE is unchanged.
- Pop:
  - rdEn with RxValid=1 advances the head and clears RxOE.
  - Head outputs (RxData/flags) are show-ahead and forced to 0 when the FIFO is empty.
- Reset mid-frame: takes effect at the next MCLK. The partial frame is lost and no flags are produced.

Decomposition:
- Shared package (eusci_uart_pkg), holding:
  - state encodings;
  - FIFO word layout constants (BRK_BIT, FE_BIT, PE_BIT and the data field);
  - cfgDataBits legal range.
- One sub-module: rx_fifo, a synchronous show-ahead FIFO parametrised by width and depth. It provides push, pop, full, empty and count, with the pop-then-push rule on full.
- Majority sampling and the FSM stay in uart_rx_engine.

Test Plan:
1. OVS=16, 8N1, LSB first, frame 0x5A -> RxBusy high from the start tick. RxValid=1 one MCLK after the mid-stop tick. RxData=0x05A, PE=FE=BRK=0, fifoCount=1.
2. 7E2, MSB first, data 0x41, parity bit wrong:
   - with RXEIE=0 -> no push, RxValid stays 0;
   - with RXEIE=1 -> entry RxData=0x41, RxPE=1.
3. Rx low for only 4 ticks at start -> false start: IDLE, RxBusy=0, fifoCount=0. A following 0x33 frame is received correctly.
4. Frames 0x01..0x05 with no pops, depth 4 -> fifoCount=4, RxOE=1. Pops return 0x01..0x04, the first pop clears RxOE, and 0x05 is lost.
5. Rx held low 12 bit times, 8N1, RXEIE=1 -> exactly one entry: data 0, FE=1, BRK=1. No further entries until Rx returns high and a new start occurs.
6. reset asserted during bit 3 of a frame -> all outputs 0 on the next MCLK. The next frame 0xA5 is received intact.
